// File: rtl/jt89_wrseq.sv
// jt89_wrseq -- command-to-PSG write sequencer.
//
// Turns high-level channel commands (tone period, volume, noise control)
// into the one- or two-byte write sequence expected by an SN76489-style PSG.
// Writes are paced by the PSG clock enable: the write strobe is low for one
// clk_en period per byte, with at least one clk_en period high between bytes.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   clk_en     PSG clock enable; the write FSM advances only when high
//   cmd_valid  command request (accepted whenever cmd_ready is high)
//   cmd_ready  queue has room for a command this cycle
//   cmd_ch     target channel 0..3 (3 = noise)
//   cmd_vol    1 = volume command, 0 = tone/noise-control command
//   cmd_val    tone period [9:0], volume [3:0] or noise control [2:0]
//   psg_ready  PSG can accept a write
//   wr_n       active-low PSG write strobe
//   dout       PSG write byte (held while wr_n is high)
//   busy       queue not empty or a write sequence in progress
//
// Configuration:
//   JT89_WRSEQ_FIFO_EN  defined   -> 4-entry command FIFO
//                       undefined -> 1-entry holding register (default)

module jt89_wrseq (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_en,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_ch,
    input  logic       cmd_vol,
    input  logic [9:0] cmd_val,
    input  logic       psg_ready,
    output logic       wr_n,
    output logic [7:0] dout,
    output logic       busy
);

    // Queued command word: {ch[12:11], vol[10], val[9:0]}
    localparam int CMD_W = 13;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LATCH = 2'd1,
        ST_GAP   = 2'd2,
        ST_DATA  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Byte formatting
    // ------------------------------------------------------------------
    function automatic logic [7:0] latch_byte(input logic [CMD_W-1:0] c);
        // Noise control uses a 3-bit field with bit 3 forced to zero
        if (c[12:11] == 2'd3 && !c[10]) begin
            return {5'b11100, c[2:0]};
        end
        return {1'b1, c[12:11], c[10], c[3:0]};
    endfunction

    function automatic logic [7:0] data_byte(input logic [CMD_W-1:0] c);
        return {2'b00, c[9:4]};
    endfunction

    // Only tone periods on channels 0..2 carry the upper six bits
    function automatic logic needs_data(input logic [CMD_W-1:0] c);
        return !c[10] && (c[12:11] != 2'd3);
    endfunction

    logic [CMD_W-1:0] cmd_word;
    logic [CMD_W-1:0] q_head;
    logic             q_full;
    logic             q_empty;
    logic             do_push;
    logic             do_pop;

    assign cmd_word  = {cmd_ch, cmd_vol, cmd_val};
    assign cmd_ready = !q_full;
    // A full queue ignores cmd_valid even if it is popped this cycle
    assign do_push   = cmd_valid && !q_full;

    // ------------------------------------------------------------------
    // Command queue
    // ------------------------------------------------------------------
`ifdef JT89_WRSEQ_FIFO_EN
    localparam int DEPTH = 4;

    logic [CMD_W-1:0] mem_q [DEPTH];
    logic [1:0]       wr_ptr_q, wr_ptr_d;
    logic [1:0]       rd_ptr_q, rd_ptr_d;
    logic [2:0]       count_q,  count_d;

    assign q_full  = (count_q == 3'(DEPTH));
    assign q_empty = (count_q == 3'd0);
    assign q_head  = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 2'd1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 2'd1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            count_q  <= 3'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage holds data only; validity lives in count_q
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= cmd_word;
        end
    end
`else
    logic [CMD_W-1:0] hold_q;
    logic             hold_vld_q, hold_vld_d;

    assign q_full  = hold_vld_q;
    assign q_empty = !hold_vld_q;
    assign q_head  = hold_q;

    // Push only happens while empty and pop only while full, so they
    // never collide in the single-entry case
    always_comb begin
        hold_vld_d = hold_vld_q;
        if (do_pop) begin
            hold_vld_d = 1'b0;
        end
        if (do_push) begin
            hold_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_vld_q <= 1'b0;
        end else begin
            hold_vld_q <= hold_vld_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            hold_q <= cmd_word;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Write FSM
    // ------------------------------------------------------------------
    state_t     state_q, state_d;
    logic       wr_n_q,  wr_n_d;
    logic [7:0] dout_q,  dout_d;
    logic [7:0] data_q,  data_d;
    logic       two_q,   two_d;

    always_comb begin
        state_d = state_q;
        wr_n_d  = wr_n_q;
        dout_d  = dout_q;
        data_d  = data_q;
        two_d   = two_q;
        do_pop  = 1'b0;
        if (clk_en) begin
            case (state_q)
                ST_IDLE: begin
                    if (!q_empty && psg_ready) begin
                        do_pop  = 1'b1;
                        dout_d  = latch_byte(q_head);
                        data_d  = data_byte(q_head);
                        two_d   = needs_data(q_head);
                        wr_n_d  = 1'b0;
                        state_d = ST_LATCH;
                    end
                end
                ST_LATCH: begin
                    wr_n_d  = 1'b1;
                    state_d = two_q ? ST_GAP : ST_IDLE;
                end
                ST_GAP: begin
                    if (psg_ready) begin
                        dout_d  = data_q;
                        wr_n_d  = 1'b0;
                        state_d = ST_DATA;
                    end
                end
                ST_DATA: begin
                    wr_n_d  = 1'b1;
                    state_d = ST_IDLE;
                end
                default: begin
                    wr_n_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Reset clears the pending second byte so an aborted command stays aborted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            wr_n_q  <= 1'b1;
            dout_q  <= 8'h00;
            two_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_n_q  <= wr_n_d;
            dout_q  <= dout_d;
            two_q   <= two_d;
        end
    end

    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    assign wr_n = wr_n_q;
    assign dout = dout_q;
    assign busy = !q_empty || (state_q != ST_IDLE);

endmodule

// File: doc/jt89_wrseq.md
JT89_WRSEQ -- requirements
Module: jt89_wrseq

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset; ports follow.
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 clk_en  input  1  PSG clock enable; FSM and write strobe advance only on cycles with clk_en=1.
REQ-005 cmd_valid  input  1  command request.
REQ-006 cmd_ready  output  1  command can be accepted this cycle.
REQ-007 cmd_ch  input  2  target channel 0..3 (3 = noise).
REQ-008 cmd_vol  input  1  1 = volume command, 0 = tone/noise-control command.
REQ-009 cmd_val  input  10  tone period, or volume in [3:0], or noise control in [2:0].
REQ-010 psg_ready  input  1  PSG can take a write.
REQ-011 wr_n  output  1  active-low PSG write strobe.
REQ-012 dout  output  8  PSG write byte.
REQ-013 busy  output  1  high while the command queue is not empty or the FSM is not IDLE.

Function
REQ-014 Accept: a command SHALL be queued on any clk edge with cmd_valid=1 and cmd_ready=1, independent of clk_en.
REQ-015 Latch byte SHALL be {1, cmd_ch, cmd_vol, cmd_val[3:0]}; for cmd_ch=3 with cmd_vol=0 it SHALL be {1,1,1,0,0,cmd_val[2:0]}.
REQ-016 Data byte {0,0,cmd_val[9:4]} SHALL be emitted only for cmd_vol=0 with cmd_ch 0..2; all other commands SHALL be single-byte.
REQ-017 FSM states: IDLE, LATCH, GAP, DATA; every transition SHALL occur only on a clk_en=1 cycle.
REQ-018 IDLE: with the queue non-empty and psg_ready=1, pop the head, drive dout=latch byte and wr_n=0, go to LATCH; otherwise stay.
REQ-019 LATCH: set wr_n=1; go to GAP for two-byte commands, else go to IDLE.
REQ-020 GAP: with psg_ready=1, drive dout=data byte and wr_n=0, go to DATA; otherwise hold.
REQ-021 DATA: set wr_n=1; go to IDLE.
REQ-022 wr_n SHALL be low for exactly one clk_en period per byte, with at least one clk_en period high between consecutive bytes.
REQ-023 dout SHALL hold its last value while wr_n=1.
REQ-024 clk_en=0 SHALL freeze the FSM, wr_n and dout.
REQ-025 Commands SHALL be written to the PSG in acceptance order, with no loss or duplication.
REQ-026 Queue full: cmd_ready=0, and cmd_valid SHALL be ignored, even if a pop happens in the same cycle.
REQ-027 Push and pop in the same cycle SHALL be legal when the queue is not full.

Reset
REQ-028 On rst=1, the block SHALL immediately set wr_n=1, dout=0x00, FSM=IDLE, queue empty, cmd_ready=1 and busy=0.
REQ-029 A reset asserted mid-write SHALL abort the command, with no remaining byte emitted after release.

Configuration
REQ-030 With macro JT89_WRSEQ_FIFO_EN defined, the queue SHALL be a 4-entry FIFO, and cmd_ready=0 only when 4 entries are held.
REQ-031 Without JT89_WRSEQ_FIFO_EN, the queue SHALL be a 1-entry holding register, and cmd_ready=1 only when it is empty; all other behaviour is unchanged.

Verification
REQ-032 clk_en every 2nd clk, psg_ready=1, cmd ch0 tone 0x2A5 -> dout 0x85 with wr_n low for one clk_en period, one high period, then 0x2A low, then busy=0.
REQ-033 cmd ch1 volume 0x7 -> single byte 0xB7; cmd ch3 tone/ctrl 0x005 -> single byte 0xE5; no data byte for either.
REQ-034 FIFO_EN, psg_ready=0, 5 back-to-back commands -> first 4 accepted, cmd_ready=0 on the 5th; psg_ready=1 -> 4 commands emitted in order, then cmd_ready=1.
REQ-035 psg_ready dropped in GAP after latch 0x85 -> wr_n stays 1 and no 0x2A until psg_ready=1, then 0x2A is emitted.
REQ-036 rst pulsed while wr_n=0 on latch 0x85 -> wr_n=1 and dout=0x00 asynchronously; no 0x2A after release; busy=0.
REQ-037 Without FIFO_EN, 2 back-to-back commands -> second held off (cmd_ready=0) until the first is popped.
